// File: rtl/spi_slave_4mb.sv
// ============================================================================
// spi_slave_4mb
// ----------------------------------------------------------------------------
// SPI mode-0 slave front end for the 4MB register block.
//
// All SPI pins are oversampled on clk_100m.  Each pin goes through a
// SYNC_STAGES-deep synchronizer and then one extra flop, and SCLK/CS_N edges
// are detected between the synchronizer output and that extra flop.  Frames
// are a fixed 56 bits, MSB first:
//
//     CMD[7:0]  ADDR[15:0]  DATA[31:0]
//
//   * Write (CMD_WR): the address is presented on addr once the address phase
//     completes.  data_mosi is loaded after the 56th SCLK rise and
//     data_mosi_rdy pulses for one cycle.
//   * Read (CMD_RD): rd_req pulses for one cycle once the address phase
//     completes.  rd_data is captured RD_LAT cycles later and shifted out on
//     spi_miso, advancing on each SCLK fall.
//   * Any other command byte is ignored until CS_N rises.  A CS_N rise before
//     a valid frame completes is an abort.  Both cases count as frame errors.
//
// Optional feature (macro SPI_ERR_CNT_EN):
//   defined   - frame_err_cnt counts aborts and bad commands, saturating at
//               8'hFF and cleared only by reset.
//   undefined - frame_err_cnt is tied to 0 and the counter is not built.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on sclk/cs_n/mosi (2..3)
//   CMD_WR       write command byte
//   CMD_RD       read command byte
//   RD_LAT       clk_100m cycles from rd_req to rd_data valid (1..3)
//
// Ports:
//   clk_100m       in   system clock, 100 MHz
//   rst_n_syn      in   synchronous active-low reset
//   spi_sclk       in   SPI clock (CPOL=0, CPHA=0), asynchronous
//   spi_cs_n       in   chip select, active-low
//   spi_mosi       in   serial data in, MSB first
//   spi_miso       out  serial data out, MSB first
//   spi_miso_oe    out  MISO output enable, high while synchronized CS_N is low
//   addr[15:0]     out  frame address, held until the next address phase ends
//   data_mosi[31:0] out write data, valid while data_mosi_rdy is high
//   data_mosi_rdy  out  one-cycle write strobe
//   rd_req         out  one-cycle read request (addr valid during it)
//   rd_data[31:0]  in   read data, sampled RD_LAT cycles after rd_req
//   frame_err_cnt[7:0] out frame error counter
// ============================================================================
module spi_slave_4mb #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_WR      = 8'h02,
    parameter logic [7:0]  CMD_RD      = 8'h03,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        clk_100m,
    input  logic        rst_n_syn,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [15:0] addr,
    output logic [31:0] data_mosi,
    output logic        data_mosi_rdy,
    output logic        rd_req,
    input  logic [31:0] rd_data,
    output logic [7:0]  frame_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RWAIT,
        S_WDATA,
        S_RDATA,
        S_DONE,
        S_IGNORE
    } state_e;

    localparam logic [1:0] RD_LAT_W = RD_LAT[1:0];

    // Bit-counter values at the rise that ends each phase.
    localparam logic [5:0] LAST_CMD_BIT  = 6'd7;
    localparam logic [5:0] LAST_ADDR_BIT = 6'd23;
    localparam logic [5:0] LAST_DATA_BIT = 6'd55;
    // MISO holds bit 31 through the fall after the last address rise; the
    // first shift happens on the fall after the first data rise.
    localparam logic [5:0] FIRST_SHIFT_CNT = 6'd25;

    // ------------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   mosi_prev_q, mosi_prev_d;

    logic sclk_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        mosi_prev_d = mosi_sync_q[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    assign cs_fall   = ~cs_s   &  cs_prev_q;

    // NOTE: the reset here is synchronous, so it sits inside the clocked
    // block.  The synchronizers reset to the bus idle levels (SCLK low,
    // CS_N high) so that leaving reset with an idle bus creates no edges.
    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mosi_prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before this edge.
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            mosi_prev_q <= mosi_prev_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------------
    state_e      state_q,         state_d;
    logic [5:0]  bit_cnt_q,       bit_cnt_d;
    logic [31:0] shift_q,         shift_d;
    logic        is_rd_q,         is_rd_d;
    logic [1:0]  lat_cnt_q,       lat_cnt_d;
    logic [31:0] miso_sr_q,       miso_sr_d;
    logic [15:0] addr_q,          addr_d;
    logic [31:0] data_mosi_q,     data_mosi_d;
    logic        data_mosi_rdy_q, data_mosi_rdy_d;
    logic        rd_req_q,        rd_req_d;
    logic        spi_miso_q,      spi_miso_d;
    logic        spi_miso_oe_q,   spi_miso_oe_d;

    logic [31:0] shift_nxt;
    logic        in_frame;
    logic        cmd_done;
    logic        cmd_ok;
    logic        addr_done;
    logic        data_done;
    logic        bad_cmd;
    logic        frame_abort;

    // The MOSI sample comes from the extra flop so that it is aligned with
    // the sclk_prev flop used for the rise detection.
    assign shift_nxt = {shift_q[30:0], mosi_prev_q};

    assign in_frame  = (state_q == S_CMD)   || (state_q == S_ADDR)  ||
                       (state_q == S_RWAIT) || (state_q == S_WDATA) ||
                       (state_q == S_RDATA);
    assign cmd_done  = (state_q == S_CMD)  && sclk_rise && (bit_cnt_q == LAST_CMD_BIT);
    assign addr_done = (state_q == S_ADDR) && sclk_rise && (bit_cnt_q == LAST_ADDR_BIT);
    assign data_done = ((state_q == S_WDATA) || (state_q == S_RDATA)) &&
                       sclk_rise && (bit_cnt_q == LAST_DATA_BIT);
    assign cmd_ok    = (shift_nxt[7:0] == CMD_WR) || (shift_nxt[7:0] == CMD_RD);
    assign bad_cmd   = cmd_done && !cmd_ok;

    // The 56th rise completes the frame before a coincident CS_N rise is
    // considered, and a bad command is already counted, so neither of those
    // is an abort.
    assign frame_abort = cs_rise && in_frame && !data_done && !bad_cmd;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        is_rd_d         = is_rd_q;
        lat_cnt_d       = lat_cnt_q;
        miso_sr_d       = miso_sr_q;
        addr_d          = addr_q;
        data_mosi_d     = data_mosi_q;
        data_mosi_rdy_d = 1'b0;
        rd_req_d        = 1'b0;
        spi_miso_oe_d   = ~cs_s;

        // The bit counter counts every SCLK rise of the frame, so the phase
        // boundaries are absolute bit positions.
        if (in_frame && sclk_rise) begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 6'd0;
                end
            end

            S_CMD: begin
                if (cmd_done) begin
                    if (cmd_ok) begin
                        is_rd_d = (shift_nxt[7:0] == CMD_RD);
                        state_d = S_ADDR;
                    end else begin
                        state_d = cs_rise ? S_IDLE : S_IGNORE;
                    end
                end
            end

            S_ADDR: begin
                if (addr_done) begin
                    addr_d = shift_nxt[15:0];
                    if (is_rd_q) begin
                        rd_req_d  = 1'b1;
                        lat_cnt_d = 2'd0;
                        state_d   = S_RWAIT;
                    end else begin
                        state_d   = S_WDATA;
                    end
                end
            end

            // lat_cnt is 0 while rd_req is high, so it reaches RD_LAT in the
            // cycle where rd_data is valid.
            S_RWAIT: begin
                if (lat_cnt_q == RD_LAT_W) begin
                    miso_sr_d = rd_data;
                    state_d   = S_RDATA;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            S_WDATA: begin
                if (data_done) begin
                    data_mosi_d     = shift_nxt;
                    data_mosi_rdy_d = 1'b1;
                    state_d         = cs_rise ? S_IDLE : S_DONE;
                end
            end

            S_RDATA: begin
                if (sclk_fall && (bit_cnt_q >= FIRST_SHIFT_CNT)) begin
                    miso_sr_d = {miso_sr_q[30:0], 1'b0};
                end
                if (data_done) begin
                    state_d = cs_rise ? S_IDLE : S_DONE;
                end
            end

            S_DONE, S_IGNORE: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An abort drops everything not yet issued.  A rd_req that was
        // issued in an earlier cycle has already gone out.
        if (frame_abort) begin
            state_d         = S_IDLE;
            addr_d          = addr_q;
            data_mosi_d     = data_mosi_q;
            data_mosi_rdy_d = 1'b0;
            rd_req_d        = 1'b0;
        end

        spi_miso_d = (state_d == S_RDATA) ? miso_sr_d[31] : 1'b0;
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= 6'd0;
            shift_q         <= 32'd0;
            is_rd_q         <= 1'b0;
            lat_cnt_q       <= 2'd0;
            miso_sr_q       <= 32'd0;
            addr_q          <= 16'd0;
            data_mosi_q     <= 32'd0;
            data_mosi_rdy_q <= 1'b0;
            rd_req_q        <= 1'b0;
            spi_miso_q      <= 1'b0;
            spi_miso_oe_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            is_rd_q         <= is_rd_d;
            lat_cnt_q       <= lat_cnt_d;
            miso_sr_q       <= miso_sr_d;
            addr_q          <= addr_d;
            data_mosi_q     <= data_mosi_d;
            data_mosi_rdy_q <= data_mosi_rdy_d;
            rd_req_q        <= rd_req_d;
            spi_miso_q      <= spi_miso_d;
            spi_miso_oe_q   <= spi_miso_oe_d;
        end
    end

    assign addr          = addr_q;
    assign data_mosi     = data_mosi_q;
    assign data_mosi_rdy = data_mosi_rdy_q;
    assign rd_req        = rd_req_q;
    assign spi_miso      = spi_miso_q;
    assign spi_miso_oe   = spi_miso_oe_q;

    // ------------------------------------------------------------------------
    // Frame error counter
    // ------------------------------------------------------------------------
`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       frame_err;

    // Abort and bad command cannot both happen in one frame, so a single
    // increment per cycle is enough.
    assign frame_err = frame_abort | bad_cmd;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign frame_err_cnt = err_cnt_q;
`else
    assign frame_err_cnt = 8'h00;
`endif

endmodule
